// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480 timing, total helpers, scan classification and colour bars.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int NUM_BARS = 8;

  // Per-pixel flags carried alongside the fetch so they land with the returned pixel.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } scan_class_t;

  typedef enum logic [2:0] {
    BAR_BLACK   = 3'b000,
    BAR_RED     = 3'b001,
    BAR_GREEN   = 3'b010,
    BAR_YELLOW  = 3'b011,
    BAR_BLUE    = 3'b100,
    BAR_MAGENTA = 3'b101,
    BAR_CYAN    = 3'b110,
    BAR_WHITE   = 3'b111
  } bar_rgb_e;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Bars left to right; bit order is {b,g,r}.
  function automatic bar_rgb_e bar_rgb(input logic [2:0] idx);
    bar_rgb_e color;
    case (idx)
      3'd0:    color = BAR_WHITE;
      3'd1:    color = BAR_YELLOW;
      3'd2:    color = BAR_CYAN;
      3'd3:    color = BAR_GREEN;
      3'd4:    color = BAR_MAGENTA;
      3'd5:    color = BAR_RED;
      3'd6:    color = BAR_BLUE;
      default: color = BAR_BLACK;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register with asynchronous active-low clear, used to align scan flags with fetch latency.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else if (pix_en) begin
      stages[0] <= data;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign delayed = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with fetch-latency realignment of the returned pixel.
// Optional colour-bar source is enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_W    = 4,
  parameter int CNT_W      = 11,
  parameter int SCALE_LOG2 = 0,
  parameter int FETCH_LAT  = 1
) (
  input  logic                 clk_25_175,
  input  logic                 reset,
  input  logic                 pix_en,
  output logic [CNT_W-1:0]     hreadwire,
  output logic [CNT_W-1:0]     vreadwire,
  input  logic [3*COLOR_W-1:0] pixstream,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 pattern_sel,
`endif
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 drawing_pixels,
  output logic                 line_start,
  output logic                 frame_start
);

  localparam int H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int CLS_W    = $bits(scan_class_t);
`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W    = H_ACTIVE / NUM_BARS;
  localparam int PIPE_W   = CLS_W + 3;
`else
  localparam int PIPE_W   = CLS_W;
`endif

  logic              rst_meta;
  logic              rst_n;
  logic [CNT_W-1:0]  hcnt;
  logic [CNT_W-1:0]  vcnt;
  scan_class_t       cls;
  scan_class_t       tail_cls;
  logic [PIPE_W-1:0] pipe_in;
  logic [PIPE_W-1:0] pipe_out;
  logic [3*COLOR_W-1:0] pixel;

  // Reset asserts asynchronously but releases only after two clock edges.
  always_ff @(posedge clk_25_175 or negedge reset) begin
    if (!reset) {rst_n, rst_meta} <= 2'b00;
    else        {rst_n, rst_meta} <= {rst_meta, 1'b1};
  end

  always_ff @(posedge clk_25_175 or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (hcnt == CNT_W'(H_TOTAL - 1)) begin
        hcnt <= '0;
        vcnt <= (vcnt == CNT_W'(V_TOTAL - 1)) ? '0 : vcnt + CNT_W'(1);
      end else begin
        hcnt <= hcnt + CNT_W'(1);
      end
    end
  end

  assign hreadwire = hcnt >> SCALE_LOG2;
  assign vreadwire = vcnt >> SCALE_LOG2;

  always_comb begin
    cls             = '0;
    cls.active      = (hcnt < CNT_W'(H_ACTIVE)) && (vcnt < CNT_W'(V_ACTIVE));
    cls.hsync       = (hcnt >= CNT_W'(HS_START)) && (hcnt < CNT_W'(HS_START + H_SYNC));
    cls.vsync       = (vcnt >= CNT_W'(VS_START)) && (vcnt < CNT_W'(VS_START + V_SYNC));
    cls.line_start  = (hcnt == '0);
    cls.frame_start = (hcnt == '0) && (vcnt == '0);
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  logic [2:0] tail_bar;
  logic [2:0] bar;

  // Bar index by threshold compare avoids a divider on the counter.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < NUM_BARS; k++)
      if (hcnt >= CNT_W'(k * BAR_W)) bar_idx = 3'(k);
  end

  assign pipe_in             = {bar_idx, cls};
  assign {tail_bar, tail_cls} = pipe_out;

  always_comb begin
    bar   = bar_rgb(tail_bar);
    pixel = pixstream;
    if (pattern_sel) pixel = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
  end
`else
  assign pipe_in  = cls;
  assign tail_cls = pipe_out;
  assign pixel    = pixstream;
`endif

  vga_delay_line #(
    .WIDTH (PIPE_W),
    .DEPTH (FETCH_LAT)
  ) u_delay (
    .clk     (clk_25_175),
    .rst_n   (rst_n),
    .pix_en  (pix_en),
    .data    (pipe_in),
    .delayed (pipe_out)
  );

  // Final stage joins the delayed flags with the pixel returned for the same coordinate.
  always_ff @(posedge clk_25_175 or negedge rst_n) begin
    if (!rst_n) begin
      r              <= '0;
      g              <= '0;
      b              <= '0;
      h_sync         <= ~HSYNC_POL;
      v_sync         <= ~VSYNC_POL;
      drawing_pixels <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
    end else if (pix_en) begin
      r              <= pixel[COLOR_W-1:0]           & {COLOR_W{tail_cls.active}};
      g              <= pixel[2*COLOR_W-1:COLOR_W]   & {COLOR_W{tail_cls.active}};
      b              <= pixel[3*COLOR_W-1:2*COLOR_W] & {COLOR_W{tail_cls.active}};
      h_sync         <= tail_cls.hsync ? HSYNC_POL : ~HSYNC_POL;
      v_sync         <= tail_cls.vsync ? VSYNC_POL : ~VSYNC_POL;
      drawing_pixels <= tail_cls.active;
      line_start     <= tail_cls.line_start;
      frame_start    <= tail_cls.frame_start;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen against a position-based raster model (reduced vertical mode).
module tb_vga_timing_gen;

  localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
  localparam int VA = 6, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FL = 3, SC = 1, CW = 4, CNT_W = 11;

  logic clk = 1'b0;
  logic reset, pix_en;
  logic [3*CW-1:0] pixstream;
  logic [CNT_W-1:0] hreadwire, vreadwire;
  logic [CW-1:0] r, g, b;
  logic h_sync, v_sync, drawing_pixels, line_start, frame_start;
`ifdef VGA_TEST_PATTERN_EN
  logic pattern_sel;
  int barR[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  int barG[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  int barB[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
`endif

  int checks = 0, failures = 0;
  int pos, syncCount;
  int shown[$];
  bit lastEn;
  int expR, expG, expB, expHs, expVs, expDraw, expLs, expFs;
  int hsRun, vsRun, drawRun, sinceFs, sinceLs;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .COLOR_W(CW), .CNT_W(CNT_W), .SCALE_LOG2(SC), .FETCH_LAT(FL)
  ) dut (
    .clk_25_175     (clk),
    .reset          (reset),
    .pix_en         (pix_en),
    .hreadwire      (hreadwire),
    .vreadwire      (vreadwire),
    .pixstream      (pixstream),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel    (pattern_sel),
`endif
    .r              (r),
    .g              (g),
    .b              (b),
    .h_sync         (h_sync),
    .v_sync         (v_sync),
    .drawing_pixels (drawing_pixels),
    .line_start     (line_start),
    .frame_start    (frame_start)
  );

  always #20 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Frame-source model: pixel value is a function of the scaled read coordinate.
  function automatic logic [3*CW-1:0] pixval(input int p);
    int hr, vr;
    hr = (p % HT) >> SC;
    vr = ((p / HT) % VT) >> SC;
    return 12'(hr * 37 + vr * 101 + 5);
  endfunction

  function automatic void setIdle();
    expR = 0; expG = 0; expB = 0;
    expHs = 1; expVs = 1;
    expDraw = 0; expLs = 0; expFs = 0;
  endfunction

  function automatic void setExpected(input int p, input bit patSel);
    int h, v, act;
    logic [3*CW-1:0] pv;
    h = p % HT;
    v = (p / HT) % VT;
    act = (h < HA && v < VA) ? 1 : 0;
    pv = pixval(p);
    expR = act ? int'(pv[3:0]) : 0;
    expG = act ? int'(pv[7:4]) : 0;
    expB = act ? int'(pv[11:8]) : 0;
    if (patSel && act == 1) begin
`ifdef VGA_TEST_PATTERN_EN
      expR = barR[h / (HA / 8)] * 15;
      expG = barG[h / (HA / 8)] * 15;
      expB = barB[h / (HA / 8)] * 15;
`endif
    end
    expHs = (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1;
    expVs = (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1;
    expDraw = act;
    expLs = (h == 0) ? 1 : 0;
    expFs = (h == 0 && v == 0) ? 1 : 0;
  endfunction

  function automatic void modelReset();
    pos = 0; syncCount = 0; lastEn = 0;
    shown.delete();
    setIdle();
    hsRun = 0; vsRun = 0; drawRun = 0; sinceFs = -1; sinceLs = -1;
  endfunction

  function automatic void modelEdge();
    bit patSel;
    patSel = 0;
`ifdef VGA_TEST_PATTERN_EN
    patSel = pattern_sel;
`endif
    lastEn = 0;
    if (!reset) modelReset();
    else if (syncCount < 2) syncCount++;
    else if (pix_en) begin
      lastEn = 1;
      shown.push_back(pos);
      if (shown.size() > FL) begin
        setExpected(shown[0], patSel);
        void'(shown.pop_front());
      end else begin
        setIdle();
      end
      pos++;
    end
  endfunction

  task automatic applyStimulus(input bit en);
    pix_en = en;
    if (reset && syncCount >= 2 && en && shown.size() >= FL)
      pixstream = pixval(shown[shown.size() - FL]);
    else
      pixstream = 12'($urandom);
  endtask

  task automatic checkAll();
    checkOutput("hreadwire", int'(hreadwire), (pos % HT) >> SC);
    checkOutput("vreadwire", int'(vreadwire), ((pos / HT) % VT) >> SC);
    checkOutput("r", int'(r), expR);
    checkOutput("g", int'(g), expG);
    checkOutput("b", int'(b), expB);
    checkOutput("h_sync", int'(h_sync), expHs);
    checkOutput("v_sync", int'(v_sync), expVs);
    checkOutput("drawing_pixels", int'(drawing_pixels), expDraw);
    checkOutput("line_start", int'(line_start), expLs);
    checkOutput("frame_start", int'(frame_start), expFs);
    if (lastEn) begin
      if (!h_sync) hsRun++;
      else if (hsRun > 0) begin checkOutput("hsync_len", hsRun, HS); hsRun = 0; end
      if (!v_sync) vsRun++;
      else if (vsRun > 0) begin checkOutput("vsync_len", vsRun, VS * HT); vsRun = 0; end
      if (drawing_pixels) drawRun++;
      else if (drawRun > 0) begin checkOutput("draw_len", drawRun, HA); drawRun = 0; end
      if (sinceFs >= 0) sinceFs++;
      if (frame_start) begin
        if (sinceFs > 0) checkOutput("frame_period", sinceFs, HT * VT);
        sinceFs = 0;
      end
      if (sinceLs >= 0) sinceLs++;
      if (line_start) begin
        if (sinceLs > 0) checkOutput("line_period", sinceLs, HT);
        sinceLs = 0;
      end
    end
  endtask

  task automatic runCycle(input bit en);
    applyStimulus(en);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; pixstream = '0;
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = 1'b1;
`endif
    #5 reset = 1'b0;
    modelReset();
    repeat (3) runCycle(1'b1);
    reset = 1'b1;
    for (int i = 0; i < 12000; i++) runCycle(1'b1);

    reset = 1'b0;
    #1;
    modelReset();
    checkAll();
    repeat (2) runCycle(1'b1);
    reset = 1'b1;
    for (int i = 0; i < 20000; i++) begin
`ifdef VGA_TEST_PATTERN_EN
      if (i % 5000 == 0) pattern_sel = $urandom_range(0, 1) != 0;
`endif
      runCycle($urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator and pixel output stage. It is the next generation of the project's VGA core. It generates the h/v scan counters, sync pulses, blanking and frame/line strobes for any mode set by parameters. It presents a (optionally downscaled) read coordinate to the frame source and realigns the returned pixel with sync/blank through a configurable fetch-latency pipeline. It sits between the pixel clock domain root and the board VGA pins, fed by the tetris frame renderer.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync lengths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync lengths in lines
- HSYNC_POL / VSYNC_POL, 0 / 0, active level of the sync pulses (0 = active-low)
- COLOR_W, 4, bits per colour channel
- CNT_W, 11, scan counter width; must hold H_TOTAL-1 and V_TOTAL-1
- SCALE_LOG2, 0, read coordinate = scan position >> SCALE_LOG2 (pixel doubling)
- FETCH_LAT, 1, cycles from read coordinate to valid pixstream, range 1..8
- clk_25_175  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel advance strobe; when low the whole block holds
- hreadwire  out  CNT_W  horizontal read coordinate to frame source
- vreadwire  out  CNT_W  vertical read coordinate to frame source
- pixstream  in  3*COLOR_W  {b,g,r} pixel, valid FETCH_LAT enabled cycles after its coordinate
- r / g / b  out  COLOR_W each  registered colour, zero outside active area
- h_sync / v_sync  out  1  registered sync at configured polarity
- drawing_pixels  out  1  registered active-area flag aligned with r/g/b
- line_start  out  1  one-cycle pulse with the first output pixel of every line
- frame_start  out  1  one-cycle pulse with output pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL are defined likewise. hcnt counts 0..H_TOTAL-1 and then wraps to 0. vcnt increments on each h wrap and wraps to 0 after V_TOTAL-1. There is no extra count at the end of a line or frame.
- hreadwire = hcnt>>SCALE_LOG2 and vreadwire = vcnt>>SCALE_LOG2. Both are driven combinationally from the counters.
- The classification of (hcnt, vcnt) travels down a FETCH_LAT+1 stage pipeline:
  - active: hcnt<H_ACTIVE and vcnt<V_ACTIVE
  - hsync: H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC
  - vsync: same pattern on the vertical constants
  - line_start: hcnt==0
  - frame_start: hcnt==0 and vcnt==0
- pixstream is sampled when the pipeline tail for its coordinate arrives. r = pixstream[COLOR_W-1:0], g is the next COLOR_W bits, b the top bits, each ANDed with active.
- pix_en low: counters, pipeline and all outputs hold their values. Strobes stay high if they were high, so downstream logic must qualify them with pix_en.
- Reset (asynchronous assert, synchronous release) sets:
  - hcnt and vcnt to 0 and every pipeline stage to 0
  - r, g, b and drawing_pixels to 0
  - line_start and frame_start to 0
  - h_sync = ~HSYNC_POL and v_sync = ~VSYNC_POL
- Reset asserted mid-frame aborts immediately. The first enabled cycle after release restarts at (0,0).

## Timing
- The output for counter position N appears FETCH_LAT+1 enabled cycles after hreadwire/vreadwire show N. All outputs are mutually aligned.
- With default mode and FETCH_LAT=1, h_sync is active for output pixels 656..751: 96 cycles, period 800 cycles.
- v_sync is active for whole lines 490..491. The frame is 525 lines, or 420000 enabled cycles.
- Every output is a flop. The only combinational paths are counter → read coordinates.

## Configuration
- VGA_TEST_PATTERN_EN defined: adds input pattern_sel (1 bit). When pattern_sel is 1, r/g/b come from eight internal vertical colour bars instead of pixstream.
  - The bars are H_ACTIVE/8 pixels wide and ordered white, yellow, cyan, green, magenta, red, blue, black.
  - Each bar channel is all-ones or zero.
  - The bars are aligned through the same pipeline as the sync signals.
- Undefined: the pattern_sel port and the bar logic are absent, and r/g/b always come from pixstream.

## Structure
- Shared package vga_pkg holds:
  - the default 640x480 timing constants
  - H_TOTAL/V_TOTAL helper functions
  - the colour-bar constants
- Sub-module vga_delay_line: shift register with parameters WIDTH and DEPTH, a pix_en enable and asynchronous active-low clear. It is used for the pipeline.

## Test plan
- Reset held low then released with pix_en=1:
  - During reset: r/g/b=0, h_sync=v_sync=1, strobes 0.
  - After release: hreadwire counts 0,1,2…
- Line wrap: hreadwire goes 799→0 and vreadwire 0→1 in the same cycle. line_start pulses once per 800 cycles.
- Sync check, defaults with FETCH_LAT=1:
  - h_sync is low for exactly 96 cycles, starting 658 cycles after the coordinate-0 cycle.
  - v_sync is low for 1600 cycles.
  - frame_start recurs every 420000 cycles.
- Pixel path: pixstream = hreadwire-derived value, delayed by FETCH_LAT=3. r/g/b match the value for the aligned pixel, are 0 in blanking, and drawing_pixels is high for 640 cycles per active line.
- pix_en toggled 1/0 and SCALE_LOG2=1:
  - All outputs freeze on pix_en=0 cycles.
  - hreadwire repeats each value for two enabled pixels and reaches a maximum of 399.
- VGA_TEST_PATTERN_EN, pattern_sel=1: output pixel 0 is {F,F,F}, pixel 80 is yellow (r=F, g=F, b=0), pixel 560 is black.
